boid_fb_writer: RTL and testbench
=================================

Name: boid_fb_writer

Overview:
- Write-side master of the 1-bit boid frame buffer whose read side feeds the VGA pixel pipeline.
- On each frame boundary it does two passes. First it erases every boid's previously drawn square (writes 0). Then it fetches each boid's new position from the position table and draws a filled square (writes 1).
- The whole frame update completes during vertical blanking, so the display scan never sees a half-updated frame.

Parameters:
NUM_BOIDS, 8, number of boids; the index runs 0..NUM_BOIDS-1.
BOID_SIZE, 2, side length in pixels of the square drawn per boid.
VIDEO_WIDTH, 640, visible width in pixels.
VIDEO_HEIGHT, 480, visible height in pixels.
PIXEL_ADDRESS_WIDTH, 20, frame-buffer address width; equals clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1.

Ports:
clk  in  1  100 MHz system clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
screenEnd  in  1  frame-boundary level from the timing generator; synchronous to clk.
boid_index  out  $clog2(NUM_BOIDS)  position-table read index.
boid_x  in  10  top-left x of the indexed boid; combinational read.
boid_y  in  9  top-left y of the indexed boid; combinational read.
fb_write_enable  out  1  frame-buffer write strobe.
fb_write_address  out  PIXEL_ADDRESS_WIDTH  write address = x + VIDEO_WIDTH*y.
fb_write_data  out  1  pixel value (1 = boid, 0 = background).
busy  out  1  high from start of an update until frame_done.
frame_done  out  1  one-cycle pulse when an update completes.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0 and the FSM enters IDLE.
  - All NUM_BOIDS per-boid valid bits clear.
  - The old-position registers (x 10b, y 9b per boid) clear.
  - Frame-buffer contents are not touched; a mid-update reset leaves partial pixels in memory.
- Start condition: screenEnd sampled high while its registered previous value is low and the FSM is in IDLE.
  - Rising edges that arrive while busy are ignored, not queued.
- FSM states: IDLE -> ERASE -> FETCH -> DRAW -> (FETCH for the next boid | DONE) -> IDLE.
- Registered write outputs; one candidate pixel per cycle.
- Iteration order:
  - Boid index ascending.
  - Inside a square, row-major with dx fastest: (dx,dy) = (0,0),(1,0),…,(S-1,0),(0,1),….
- ERASE:
  - Visits NUM_BOIDS*BOID_SIZE^2 candidate pixels at the old positions, writing data 0.
  - A boid whose valid bit is 0 still consumes its cycles, with write_enable 0.
- FETCH:
  - One cycle; drive boid_index = i, then latch boid_x and boid_y at the end of the cycle.
- DRAW:
  - BOID_SIZE^2 cycles writing data 1 at the latched position.
  - At the end of DRAW, copy the position into boid i's old-position register and set valid[i].
- Clipping: a candidate with x+dx >= VIDEO_WIDTH or y+dy >= VIDEO_HEIGHT still takes its cycle, with write_enable 0. There is no wrap-around.
- Address arithmetic: computed at PIXEL_ADDRESS_WIDTH bits, with no truncation; the maximum is 307199.
- Cycle timing, where T0 is the clk edge that detects the start:
  - busy rises at T0+1, and the first erase candidate is presented at T0+1.
  - Total candidate-plus-fetch cycles: N*S^2 + N*(1+S^2); for the defaults, 32 + 40 = 72.
  - The DONE cycle follows the last draw candidate: frame_done = 1 and busy falls in that same cycle.
  - Return to IDLE on the next cycle.
- Overlap:
  - Because all erases precede all draws, overlapping boids never erase each other's new pixels.
  - A later draw overwriting an earlier one is harmless, since both write 1.
- When write_enable is 0, fb_write_address and fb_write_data hold their last values.

Test Plan:
- Reset then first frame: assert reset=0, release, pulse screenEnd; boid 0 at (10,20), S=2 -> no erase writes (all valid bits 0). Draw writes go to 12810, 12811, 13450, 13451, each with data 1. frame_done is high exactly 72 cycles after busy rises.
- Second frame after boid 0 moves to (11,20) -> erase writes data 0 at 12810, 12811, 13450, 13451, and every erase precedes every draw write. Draw writes go to 12811, 12812, 13451, 13452.
- Clipping: boid at (639,479) -> exactly one draw write, at 307199. The other three candidates have write_enable 0, and the cycle count is unchanged.
- screenEnd rising again while busy -> no restart. After frame_done, busy stays 0 until the next rising edge; screenEnd held high produces only one update.
- Reset asserted mid-DRAW -> fb_write_enable, busy and frame_done go to 0 asynchronously. The next update performs no erase writes.
- All 8 boids at the same position (100,100) -> 32 draw writes, all data 1. The following frame issues 32 erase writes to the same 4 addresses before any draw write.

Source files
------------

// File: rtl/boid_fb_writer.sv
// Frame-buffer write master for the boid display: erases every old square,
// then draws every new square, once per frame boundary.
module boid_fb_writer #(
    parameter int NUM_BOIDS           = 8,
    parameter int BOID_SIZE           = 2,
    parameter int VIDEO_WIDTH         = 640,
    parameter int VIDEO_HEIGHT        = 480,
    parameter int PIXEL_ADDRESS_WIDTH = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           screenEnd,
    output logic [$clog2(NUM_BOIDS)-1:0]   boid_index,
    input  logic [9:0]                     boid_x,
    input  logic [8:0]                     boid_y,
    output logic                           fb_write_enable,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] fb_write_address,
    output logic                           fb_write_data,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int IW  = $clog2(NUM_BOIDS);
    localparam int SW  = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
    localparam int PAW = PIXEL_ADDRESS_WIDTH;
    localparam logic [IW-1:0] B_LAST = IW'(NUM_BOIDS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(BOID_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        FETCH,
        DRAW,
        DONE
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] bi, bi_n;
    logic [SW-1:0] dx, dx_n;
    logic [SW-1:0] dy, dy_n;
    logic          se_prev;
    logic          start;
    logic          last_px;
    logic          last_b;
    logic          draw_end;

    logic [9:0]           lat_x;
    logic [8:0]           lat_y;
    logic [9:0]           old_x [NUM_BOIDS];
    logic [8:0]           old_y [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] valid;

    logic [9:0]     sx;
    logic [8:0]     sy;
    logic           en_src;
    logic           data_c;
    logic [10:0]    cx;
    logic [9:0]     cy;
    logic [PAW-1:0] addr_c;
    logic           we_n;
    logic [PAW-1:0] addr_n;
    logic           data_n;
    logic           busy_n;
    logic           done_n;

    assign start      = screenEnd && !se_prev && (state == IDLE);
    assign last_px    = (dx == S_LAST) && (dy == S_LAST);
    assign last_b     = (bi == B_LAST);
    assign draw_end   = (state == DRAW) && last_px;
    assign boid_index = bi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bi      <= '0;
            dx      <= '0;
            dy      <= '0;
            se_prev <= 1'b0;
        end else begin
            state   <= state_n;
            bi      <= bi_n;
            dx      <= dx_n;
            dy      <= dy_n;
            se_prev <= screenEnd;
        end
    end

    always_comb begin
        state_n = state;
        bi_n    = bi;
        dx_n    = dx;
        dy_n    = dy;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ERASE;
                    bi_n    = '0;
                    dx_n    = '0;
                    dy_n    = '0;
                end
            end
            ERASE, DRAW: begin
                if (dx != S_LAST) begin
                    dx_n = dx + 1'b1;
                end else begin
                    dx_n = '0;
                    if (dy != S_LAST) begin
                        dy_n = dy + 1'b1;
                    end else begin
                        dy_n = '0;
                        if (last_b) begin
                            bi_n    = '0;
                            state_n = (state == ERASE) ? FETCH : DONE;
                        end else begin
                            bi_n    = bi + 1'b1;
                            state_n = (state == ERASE) ? ERASE : FETCH;
                        end
                    end
                end
            end
            FETCH: begin
                state_n = DRAW;
                dx_n    = '0;
                dy_n    = '0;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed for the next cycle's candidate so they register
    // in the same cycle the state machine presents that candidate.
    always_comb begin
        sx     = lat_x;
        sy     = lat_y;
        en_src = 1'b0;
        data_c = 1'b0;
        case (state_n)
            ERASE: begin
                sx     = old_x[bi_n];
                sy     = old_y[bi_n];
                en_src = valid[bi_n];
            end
            DRAW: begin
                if (state == FETCH) begin
                    sx = boid_x;
                    sy = boid_y;
                end
                en_src = 1'b1;
                data_c = 1'b1;
            end
            default: ;
        endcase
        cx     = {1'b0, sx} + 11'(dx_n);
        cy     = {1'b0, sy} + 10'(dy_n);
        addr_c = PAW'(cx) + PAW'(cy) * PAW'(VIDEO_WIDTH);
        we_n   = en_src && (cx < 11'(VIDEO_WIDTH))
                 && (cy < 10'(VIDEO_HEIGHT));
        addr_n = we_n ? addr_c : fb_write_address;
        data_n = we_n ? data_c : fb_write_data;
        busy_n = state_n inside {ERASE, FETCH, DRAW};
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_write_enable  <= 1'b0;
            fb_write_address <= '0;
            fb_write_data    <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            lat_x            <= '0;
            lat_y            <= '0;
            valid            <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                old_x[i] <= '0;
                old_y[i] <= '0;
            end
        end else begin
            fb_write_enable  <= we_n;
            fb_write_address <= addr_n;
            fb_write_data    <= data_n;
            busy             <= busy_n;
            frame_done       <= done_n;
            if (state == FETCH) begin
                lat_x <= boid_x;
                lat_y <= boid_y;
            end
            if (draw_end) begin
                old_x[bi] <= lat_x;
                old_y[bi] <= lat_y;
                valid[bi] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boid_fb_writer.sv
// Directed bench for boid_fb_writer: frame write sequences, timing,
// clipping, busy-time restarts and asynchronous reset.
module tb_boid_fb_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        screenEnd;
    logic [2:0]  boid_index;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic        fb_write_enable;
    logic [19:0] fb_write_address;
    logic        fb_write_data;
    logic        busy;
    logic        frame_done;

    logic [9:0] px [8];
    logic [8:0] py [8];

    int errs   = 0;
    int checks = 0;
    int wa[$];
    int wd[$];
    int ea[$];
    int ed[$];

    always #5 clk = ~clk;

    assign boid_x = px[boid_index];
    assign boid_y = py[boid_index];

    boid_fb_writer dut (
        .clk              (clk),
        .reset            (reset),
        .screenEnd        (screenEnd),
        .boid_index       (boid_index),
        .boid_x           (boid_x),
        .boid_y           (boid_y),
        .fb_write_enable  (fb_write_enable),
        .fb_write_address (fb_write_address),
        .fb_write_data    (fb_write_data),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always @(negedge clk) begin
        if (fb_write_enable === 1'b1) begin
            wa.push_back(int'(fb_write_address));
            wd.push_back(int'(fb_write_data));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_clear();
        ea.delete();
        ed.delete();
    endtask

    task automatic exp_push(input int a, input int d);
        ea.push_back(a);
        ed.push_back(d);
    endtask

    // Square whose top-left address is a, fully on screen.
    task automatic exp_sq(input int a, input int d);
        exp_push(a, d);
        exp_push(a + 1, d);
        exp_push(a + 640, d);
        exp_push(a + 641, d);
    endtask

    task automatic park();
        for (int i = 0; i < 8; i++) begin
            px[i] = 10'd1000;
            py[i] = 9'd500;
        end
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_nwr"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
            check($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
        end
    endtask

    // mode 0: one-cycle screenEnd pulse.
    // mode 1: held high, with an extra rising edge while busy.
    task automatic run_frame(input string tag, input int mode);
        int n;
        int b;
        wa.delete();
        wd.delete();
        screenEnd = 1'b1;
        @(negedge clk);
        if (mode == 0) screenEnd = 1'b0;
        check({tag, "_busy_rise"}, int'(busy), 1);
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 10) screenEnd = 1'b0;
            if (mode == 1 && n == 12) screenEnd = 1'b1;
        end
        check({tag, "_done_cycles"}, n, 72);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(frame_done), 0);
        b = 0;
        repeat (20) begin
            @(negedge clk);
            b += int'(busy);
        end
        check({tag, "_stay_idle"}, b, 0);
        screenEnd = 1'b0;
        @(negedge clk);
        cmp_writes(tag);
    endtask

    initial begin
        reset     = 1'b0;
        screenEnd = 1'b0;
        park();
        repeat (3) @(negedge clk);
        check("rst_we", int'(fb_write_enable), 0);
        check("rst_addr", int'(fb_write_address), 0);
        check("rst_data", int'(fb_write_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_index", int'(boid_index), 0);
        reset = 1'b1;
        @(negedge clk);

        px[0] = 10'd10;
        py[0] = 9'd20;
        exp_clear();
        exp_sq(12810, 1);
        run_frame("f1", 0);

        px[0] = 10'd11;
        exp_clear();
        exp_sq(12810, 0);
        exp_sq(12811, 1);
        run_frame("f2", 0);

        px[0] = 10'd639;
        py[0] = 9'd479;
        exp_clear();
        exp_sq(12811, 0);
        exp_push(307199, 1);
        run_frame("f3_clip", 0);

        exp_clear();
        exp_push(307199, 0);
        exp_push(307199, 1);
        run_frame("f4_held", 1);

        px[0] = 10'd10;
        py[0] = 9'd20;
        screenEnd = 1'b1;
        @(negedge clk);
        screenEnd = 1'b0;
        check("mid_busy", int'(busy), 1);
        repeat (34) @(negedge clk);
        check("mid_we", int'(fb_write_enable), 1);
        check("mid_addr", int'(fb_write_address), 12811);
        #1 reset = 1'b0;
        #1;
        check("async_we", int'(fb_write_enable), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(frame_done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        exp_clear();
        exp_sq(12810, 1);
        run_frame("f6_after_rst", 0);

        for (int i = 0; i < 8; i++) begin
            px[i] = 10'd100;
            py[i] = 9'd100;
        end
        exp_clear();
        exp_sq(12810, 0);
        repeat (8) exp_sq(64100, 1);
        run_frame("f7_stack", 0);

        exp_clear();
        repeat (8) exp_sq(64100, 0);
        repeat (8) exp_sq(64100, 1);
        run_frame("f8_stack", 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
